// File: rtl/game_sequencer.sv
// Game-flow controller for the paddle game: sequences idle/serve/play/miss/over,
// gates ball motion, and keeps the BCD score, lives and speed level.
module game_sequencer #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int SPEEDUP_HITS = 5,
  parameter int MAX_SPEED    = 7
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_tick,
  input  logic        hit,
  input  logic        miss,
  output logic        run,
  output logic        ball_rst,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic [2:0]  speed,
  output logic        game_over,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_MISSED = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        run_q, run_d;
  logic        ball_rst_q, ball_rst_d;
  logic [15:0] score_q, score_d;
  logic [2:0]  lives_q, lives_d;
  logic [2:0]  speed_q, speed_d;
  logic        game_over_q, game_over_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [3:0]  hit_cnt_q, hit_cnt_d;
  logic        start_d_q;

  logic start_re;
  logic serve_done;
  logic miss_done;
  logic start_act;

  assign start_re   = start & ~start_d_q;
  assign serve_done = (state_q == ST_SERVE)  && frame_tick && (frame_cnt_q == 8'(SERVE_FRAMES - 1));
  assign miss_done  = (state_q == ST_MISSED) && frame_tick && (frame_cnt_q == 8'(MISS_FRAMES - 1));
  assign start_act  = ((state_q == ST_IDLE) || (state_q == ST_OVER)) && start_re;

  // Ripple of four BCD digit incrementers; caller handles the 9999 ceiling.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    logic [3:0]  dig;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dig = v[4*i +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = dig + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      ball_rst_q  <= 1'b0;
      score_q     <= 16'h0000;
      lives_q     <= 3'(LIVES);
      speed_q     <= 3'd1;
      game_over_q <= 1'b0;
      frame_cnt_q <= 8'd0;
      hit_cnt_q   <= 4'd0;
      start_d_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      ball_rst_q  <= ball_rst_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      speed_q     <= speed_d;
      game_over_q <= game_over_d;
      frame_cnt_q <= frame_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      start_d_q   <= start;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_re)   state_d = ST_SERVE;
      ST_SERVE:  if (serve_done) state_d = ST_PLAY;
      ST_PLAY:   if (miss)       state_d = (lives_q == 3'd1) ? ST_OVER : ST_MISSED;
      ST_MISSED: if (miss_done)  state_d = ST_SERVE;
      ST_OVER:   if (start_re)   state_d = ST_SERVE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    score_d     = score_q;
    lives_d     = lives_q;
    speed_d     = speed_q;
    frame_cnt_d = frame_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    run_d       = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
    ball_rst_d  = start_act || miss_done;

    if (start_act) begin
      score_d     = 16'h0000;
      lives_d     = 3'(LIVES);
      speed_d     = 3'd1;
      frame_cnt_d = 8'd0;
      hit_cnt_d   = 4'd0;
    end else if ((state_q == ST_SERVE) || (state_q == ST_MISSED)) begin
      if (serve_done || miss_done) frame_cnt_d = 8'd0;
      else if (frame_tick)         frame_cnt_d = frame_cnt_q + 8'd1;
    end else if (state_q == ST_PLAY) begin
      // A simultaneous hit is dropped when the ball is missed.
      if (miss) begin
        lives_d     = lives_q - 3'd1;
        frame_cnt_d = 8'd0;
      end else if (hit) begin
        if (score_q != 16'h9999) score_d = bcd_inc(score_q);
        if (hit_cnt_q == 4'(SPEEDUP_HITS - 1)) begin
          hit_cnt_d = 4'd0;
          if (speed_q < 3'(MAX_SPEED)) speed_d = speed_q + 3'd1;
        end else begin
          hit_cnt_d = hit_cnt_q + 4'd1;
        end
      end
    end
  end

  assign run       = run_q;
  assign ball_rst  = ball_rst_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign speed     = speed_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: serve timing, scoring, BCD carry and
// saturation, miss/lives/game-over flow, hit+miss collision and reset.
module tb_game_sequencer;

  logic        clk_100MHz = 1'b0;
  logic        reset      = 1'b1;
  logic        start      = 1'b0;
  logic        frame_tick = 1'b0;
  logic        hit        = 1'b0;
  logic        miss       = 1'b0;
  logic        run;
  logic        ball_rst;
  logic [15:0] score;
  logic [2:0]  lives;
  logic [2:0]  speed;
  logic        game_over;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  game_sequencer dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start      (start),
    .frame_tick (frame_tick),
    .hit        (hit),
    .miss       (miss),
    .run        (run),
    .ball_rst   (ball_rst),
    .score      (score),
    .lives      (lives),
    .speed      (speed),
    .game_over  (game_over),
    .state      (state)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    cyc(n);
    frame_tick = 1'b0;
  endtask

  task automatic hits(input int n);
    hit = 1'b1;
    cyc(n);
    hit = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},    16'(state),     16'd0);
    chk({tag, "_run"},      16'(run),       16'd0);
    chk({tag, "_ball_rst"}, 16'(ball_rst),  16'd0);
    chk({tag, "_score"},    score,          16'h0000);
    chk({tag, "_lives"},    16'(lives),     16'd3);
    chk({tag, "_speed"},    16'(speed),     16'd1);
    chk({tag, "_over"},     16'(game_over), 16'd0);
  endtask

  initial begin
    cyc(2);
    chk_reset_vals("rst");
    reset = 1'b0;
    cyc(1);

    // Start edge -> SERVE with a one-cycle ball_rst.
    start = 1'b1;
    cyc(1);
    chk("start_state", 16'(state), 16'd1);
    chk("start_brst", 16'(ball_rst), 16'd1);
    cyc(1);
    chk("brst_width", 16'(ball_rst), 16'd0);
    ticks(59);
    chk("serve59_state", 16'(state), 16'd1);
    chk("serve59_run", 16'(run), 16'd0);
    ticks(1);
    chk("serve60_state", 16'(state), 16'd2);
    chk("serve60_run", 16'(run), 16'd1);

    // 12 hits with start held high the whole time.
    hits(12);
    chk("h12_score", score, 16'h0012);
    chk("h12_speed", 16'(speed), 16'd3);
    chk("h12_state", 16'(state), 16'd2);
    chk("h12_brst", 16'(ball_rst), 16'd0);
    start = 1'b0;

    hits(87);
    chk("h99_score", score, 16'h0099);
    hits(1);
    chk("h100_score", score, 16'h0100);
    hits(9899);
    chk("h9999_score", score, 16'h9999);
    chk("h9999_speed", 16'(speed), 16'd7);
    hits(1);
    chk("sat_score", score, 16'h9999);

    // Miss 1
    miss = 1'b1; cyc(1); miss = 1'b0;
    chk("m1_lives", 16'(lives), 16'd2);
    chk("m1_state", 16'(state), 16'd3);
    chk("m1_run", 16'(run), 16'd0);
    hits(2);
    chk("m1_hit_ignored", score, 16'h9999);
    ticks(89);
    chk("m1_89_state", 16'(state), 16'd3);
    ticks(1);
    chk("m1_90_state", 16'(state), 16'd1);
    chk("m1_90_brst", 16'(ball_rst), 16'd1);
    ticks(60);
    chk("m1_serve_state", 16'(state), 16'd2);
    chk("m1_speed_kept", 16'(speed), 16'd7);

    // Miss 2
    miss = 1'b1; cyc(1); miss = 1'b0;
    chk("m2_lives", 16'(lives), 16'd1);
    ticks(90);
    ticks(60);
    chk("m2_state", 16'(state), 16'd2);

    // Miss 3 -> OVER
    miss = 1'b1; cyc(1); miss = 1'b0;
    chk("m3_lives", 16'(lives), 16'd0);
    chk("m3_state", 16'(state), 16'd4);
    chk("m3_over", 16'(game_over), 16'd1);
    chk("m3_run", 16'(run), 16'd0);
    ticks(5);
    chk("over_hold_score", score, 16'h9999);
    chk("over_hold_state", 16'(state), 16'd4);

    // Restart from OVER
    start = 1'b1; cyc(1); start = 1'b0;
    chk("rs_state", 16'(state), 16'd1);
    chk("rs_score", score, 16'h0000);
    chk("rs_lives", 16'(lives), 16'd3);
    chk("rs_speed", 16'(speed), 16'd1);
    chk("rs_over", 16'(game_over), 16'd0);
    chk("rs_brst", 16'(ball_rst), 16'd1);

    // Same-cycle hit and miss at score 0004
    ticks(60);
    hits(4);
    chk("hm_pre_score", score, 16'h0004);
    hit = 1'b1; miss = 1'b1; cyc(1); hit = 1'b0; miss = 1'b0;
    chk("hm_score", score, 16'h0004);
    chk("hm_lives", 16'(lives), 16'd2);
    chk("hm_state", 16'(state), 16'd3);

    // Reset with MISSED count at 40
    ticks(40);
    chk("mid_missed_state", 16'(state), 16'd3);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk_reset_vals("midrst");
    hits(3);
    chk("idle_hit_score", score, 16'h0000);
    chk("idle_hit_state", 16'(state), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
